// File: rtl/debug_controller.sv
// UART debug sequencer for the MIPS core: loads instruction memory, runs or
// single-steps the core, then streams PC and register file back over UART.
module debug_controller #(
  parameter int NB_ADDR    = 32,
  parameter int NB_INST    = 32,
  parameter int NB_DATA    = 32,
  parameter int NB_REG     = 5,
  parameter int N_REGS     = 32,
  parameter int IMEM_WORDS = 256
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_data,
  output logic               o_imem_write,
  output logic [NB_ADDR-1:0] o_imem_addr,
  output logic [NB_INST-1:0] o_imem_data,
  output logic               o_cpu_reset_n,
  output logic               o_cpu_enable,
  input  logic               i_halt,
  input  logic [NB_ADDR-1:0] i_pc,
  output logic [NB_REG-1:0]  o_reg_addr,
  input  logic [NB_DATA-1:0] i_reg_data,
  output logic               o_busy
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(N_REGS + 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, ACK_SEND, ACK_WAIT, RUN, STEP,
    DUMP_PC, DUMP_SEND, DUMP_WAIT, DUMP_ADDR, DUMP_LATCH
  } state_t;

  state_t             state, state_n;
  logic [NB_INST-1:0] word, word_n;
  logic [1:0]         bcnt, bcnt_n;
  logic [IW-1:0]      idx, idx_n;
  logic [NB_DATA-1:0] sh, sh_n;
  logic [DW-1:0]      dw, dw_n;
  logic [7:0]         tx_data_n;
  logic               imem_write_n;
  logic [NB_ADDR-1:0] imem_addr_n;
  logic [NB_INST-1:0] imem_data_n;
  logic               enable_n;
  logic [NB_REG-1:0]  reg_addr_n;

  assign o_tx_start    = (state == DUMP_SEND) || (state == ACK_SEND);
  assign o_cpu_reset_n = (state != LOAD);
  assign o_busy        = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state        <= IDLE;
      word         <= '0;
      bcnt         <= '0;
      idx          <= '0;
      sh           <= '0;
      dw           <= '0;
      o_tx_data    <= '0;
      o_imem_write <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_data  <= '0;
      o_cpu_enable <= 1'b0;
      o_reg_addr   <= '0;
    end else begin
      state        <= state_n;
      word         <= word_n;
      bcnt         <= bcnt_n;
      idx          <= idx_n;
      sh           <= sh_n;
      dw           <= dw_n;
      o_tx_data    <= tx_data_n;
      o_imem_write <= imem_write_n;
      o_imem_addr  <= imem_addr_n;
      o_imem_data  <= imem_data_n;
      o_cpu_enable <= enable_n;
      o_reg_addr   <= reg_addr_n;
    end
  end

  always_comb begin
    state_n      = state;
    word_n       = word;
    bcnt_n       = bcnt;
    idx_n        = idx;
    sh_n         = sh;
    dw_n         = dw;
    tx_data_n    = o_tx_data;
    imem_write_n = 1'b0;
    imem_addr_n  = o_imem_addr;
    imem_data_n  = o_imem_data;
    enable_n     = 1'b0;
    reg_addr_n   = o_reg_addr;

    unique case (state)
      IDLE: begin
        if (i_rx_done) begin
          case (i_rx_data)
            8'h4C: begin
              state_n = LOAD;
              idx_n   = '0;
              bcnt_n  = '0;
            end
            8'h52: state_n = RUN;
            8'h53: begin
              state_n  = STEP;
              enable_n = ~i_halt;
            end
            8'h44: state_n = DUMP_PC;
            default: ;
          endcase
        end
      end
      LOAD: begin
        if (i_rx_done) begin
          word_n = {word[NB_INST-9:0], i_rx_data};
          bcnt_n = bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            imem_write_n = 1'b1;
            imem_data_n  = word_n;
            imem_addr_n  = NB_ADDR'(idx) << 2;
            idx_n        = idx + IW'(1);
            if (word_n == '1 || idx == IW'(IMEM_WORDS - 1)) begin
              state_n   = ACK_SEND;
              tx_data_n = 8'h06;
            end
          end
        end
      end
      ACK_SEND: state_n = ACK_WAIT;
      ACK_WAIT: if (i_tx_done) state_n = IDLE;
      // Enable is registered, so it rises one cycle after RUN is entered and
      // drops on the edge that samples i_halt.
      RUN: begin
        if (i_halt) state_n = DUMP_PC;
        else        enable_n = 1'b1;
      end
      STEP: state_n = DUMP_PC;
      DUMP_PC: begin
        sh_n       = NB_DATA'(i_pc);
        bcnt_n     = '0;
        dw_n       = '0;
        reg_addr_n = '0;
        tx_data_n  = sh_n[NB_DATA-1 -: 8];
        state_n    = DUMP_SEND;
      end
      DUMP_SEND: state_n = DUMP_WAIT;
      // dw counts finished words: 0 is the PC, r+1 is register r.
      DUMP_WAIT: begin
        if (i_tx_done) begin
          sh_n   = sh << 8;
          bcnt_n = bcnt + 2'd1;
          if (bcnt != 2'd3) begin
            tx_data_n = sh_n[NB_DATA-1 -: 8];
            state_n   = DUMP_SEND;
          end else if (dw == DW'(N_REGS)) begin
            state_n = IDLE;
          end else begin
            reg_addr_n = NB_REG'(dw);
            dw_n       = dw + DW'(1);
            state_n    = DUMP_ADDR;
          end
        end
      end
      DUMP_ADDR: state_n = DUMP_LATCH;
      DUMP_LATCH: begin
        sh_n      = i_reg_data;
        tx_data_n = sh_n[NB_DATA-1 -: 8];
        state_n   = DUMP_SEND;
      end
    endcase
  end

endmodule

// File: tb/tb_debug_controller.sv
// Randomized scoreboard bench for debug_controller with a UART tx stub and a
// synchronous register-file model.
module tb_debug_controller;
  localparam int N_REGS     = 32;
  localparam int IMEM_WORDS = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic        tx_done = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] reg_data = '0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        imem_write;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        cpu_reset_n;
  logic        cpu_enable;
  logic [4:0]  reg_addr;
  logic        busy;

  logic [31:0] regs [N_REGS];
  int total = 0;
  int bad = 0;
  int en_cnt = 0;
  int tx_seen = 0;
  logic [7:0]  exp_tx [$];
  logic [63:0] exp_wr [$];

  debug_controller #(
    .NB_ADDR(32), .NB_INST(32), .NB_DATA(32), .NB_REG(5),
    .N_REGS(N_REGS), .IMEM_WORDS(IMEM_WORDS)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .o_imem_write(imem_write), .o_imem_addr(imem_addr), .o_imem_data(imem_data),
    .o_cpu_reset_n(cpu_reset_n), .o_cpu_enable(cpu_enable), .i_halt(halt),
    .i_pc(pc), .o_reg_addr(reg_addr), .i_reg_data(reg_data), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // register file: read data valid one cycle after the address
  always @(posedge clk) reg_data <= regs[reg_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: pops expected tx bytes and imem writes as the DUT presents them
  initial begin
    forever begin
      @(negedge clk);
      if (cpu_enable) en_cnt++;
      if (tx_start) begin
        if (exp_tx.size() == 0) chk("tx_unexpected", tx_start, 0);
        else chk("tx_byte", tx_data, exp_tx.pop_front());
        tx_seen++;
      end
      if (imem_write) begin
        if (exp_wr.size() == 0) chk("imem_write_unexpected", imem_write, 0);
        else chk("imem_write_addr_data", {imem_addr, imem_data}, exp_wr.pop_front());
      end
    end
  end

  // uart_tx stub: random byte time, checks data stability while sending
  initial begin
    logic [7:0] cap;
    int d;
    bit ab;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (tx_start) begin
        cap = tx_data;
        ab = 1'b0;
        d = $urandom_range(1, 4);
        repeat (d) begin
          @(negedge clk);
          if (!rst_n) ab = 1'b1;
          if (!ab) begin
            chk("tx_data_stable", tx_data, cap);
            chk("tx_start_single", tx_start, 0);
          end
        end
        tx_done = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic wait_idle(input string nm, input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic post(input string nm, input int en_exp);
    chk({nm, "_tx_pending"}, exp_tx.size(), 0);
    chk({nm, "_wr_pending"}, exp_wr.size(), 0);
    chk({nm, "_enable_cycles"}, en_cnt, en_exp);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_tx_start"}, tx_start, 0);
    chk({nm, "_tx_data"}, tx_data, 0);
    chk({nm, "_imem_write"}, imem_write, 0);
    chk({nm, "_imem_addr"}, imem_addr, 0);
    chk({nm, "_imem_data"}, imem_data, 0);
    chk({nm, "_cpu_reset_n"}, cpu_reset_n, 1);
    chk({nm, "_cpu_enable"}, cpu_enable, 0);
    chk({nm, "_reg_addr"}, reg_addr, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  task automatic randomize_core();
    for (int r = 0; r < N_REGS; r++) regs[r] = $urandom;
    pc = $urandom;
  endtask

  // expected dump: PC then every register, each MSB first
  task automatic push_dump(input logic [31:0] pcv);
    logic [31:0] w;
    for (int r = -1; r < N_REGS; r++) begin
      w = (r < 0) ? pcv : regs[r];
      exp_tx.push_back(w[31:24]);
      exp_tx.push_back(w[23:16]);
      exp_tx.push_back(w[15:8]);
      exp_tx.push_back(w[7:0]);
    end
  endtask

  task automatic do_load(input string nm, input logic [7:0] bytes [$]);
    int nw = 0;
    bit done = 1'b0;
    logic [31:0] w;
    for (int i = 0; i + 3 < bytes.size() && !done; i += 4) begin
      w = {bytes[i], bytes[i+1], bytes[i+2], bytes[i+3]};
      exp_wr.push_back({32'(nw * 4), w});
      nw++;
      if (w == 32'hFFFF_FFFF || nw == IMEM_WORDS) begin
        exp_tx.push_back(8'h06);
        done = 1'b1;
      end
    end
    en_cnt = 0;
    send_byte(8'h4C);
    chk({nm, "_cpu_reset_n_low"}, cpu_reset_n, 0);
    chk({nm, "_busy"}, busy, 1);
    foreach (bytes[i]) send_byte(bytes[i]);
    wait_idle(nm, 400);
    chk({nm, "_cpu_reset_n_high"}, cpu_reset_n, 1);
    post(nm, 0);
  endtask

  initial begin
    logic [7:0] q [$];
    logic [31:0] w;
    int hi;
    int n;

    for (int r = 0; r < N_REGS; r++) regs[r] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;

    // unknown command byte
    en_cnt = 0;
    send_byte(8'h7A);
    repeat (5) begin
      @(negedge clk);
      chk("unknown_busy", busy, 0);
    end
    post("unknown", 0);

    // fixed load: one word then HALT
    q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_load("load_fixed", q);

    // random load terminated by HALT
    q.delete();
    repeat ($urandom_range(3, 8)) begin
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = '0;
      q.push_back(w[31:24]); q.push_back(w[23:16]); q.push_back(w[15:8]); q.push_back(w[7:0]);
    end
    repeat (4) q.push_back(8'hFF);
    do_load("load_rand", q);

    // single step, with a command byte sent mid-dump that must be dropped
    randomize_core();
    halt = 1'b0;
    en_cnt = 0;
    push_dump(pc);
    send_byte(8'h53);
    repeat (40) @(negedge clk);
    send_byte(8'h4C);
    wait_idle("step", 4000);
    post("step", 1);

    // run, halt after 10 enabled cycles
    randomize_core();
    en_cnt = 0;
    push_dump(pc);
    send_byte(8'h52);
    hi = 0;
    n = 0;
    while (hi < 10 && n < 200) begin
      @(negedge clk);
      n++;
      if (cpu_enable) hi++;
    end
    halt = 1'b1;
    wait_idle("run", 4000);
    post("run", 10);

    // run and step with halt already high
    randomize_core();
    en_cnt = 0;
    push_dump(pc);
    send_byte(8'h52);
    wait_idle("run_halted", 4000);
    post("run_halted", 0);
    randomize_core();
    en_cnt = 0;
    push_dump(pc);
    send_byte(8'h53);
    wait_idle("step_halted", 4000);
    post("step_halted", 0);
    halt = 1'b0;

    // reset during dump at byte 37, then a clean dump
    randomize_core();
    en_cnt = 0;
    tx_seen = 0;
    push_dump(pc);
    send_byte(8'h44);
    n = 0;
    while (tx_seen < 37 && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("midreset_byte_count", tx_seen, 37);
    rst_n = 1'b0;
    exp_tx.delete();
    @(posedge clk); #1;
    check_reset_vals("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    randomize_core();
    push_dump(pc);
    send_byte(8'h44);
    wait_idle("dump_after_reset", 4000);
    post("dump_after_reset", 0);

    // full memory without HALT, trailing bytes dropped
    q.delete();
    repeat (IMEM_WORDS) begin
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = '0;
      q.push_back(w[31:24]); q.push_back(w[23:16]); q.push_back(w[15:8]); q.push_back(w[7:0]);
    end
    repeat (8) q.push_back(8'h11);
    do_load("load_full", q);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
